// File: rtl/mage_pkg.sv
// Shared types and default sizes for the loop induction-variable generator.
package mage_pkg;

    localparam int N_LOOPS_DEF   = 4;
    localparam int NBIT_LP_IV    = 8;
    localparam int NBIT_ITER_CNT = 24;
    localparam int NBIT_N_ACTIVE = $clog2(N_LOOPS_DEF + 1);

    typedef enum logic [1:0] {
        LP_IDLE = 2'd0,
        LP_RUN  = 2'd1,
        LP_DONE = 2'd2
    } lp_iv_state_e;

    typedef struct packed {
        logic [N_LOOPS_DEF*NBIT_LP_IV-1:0] bound;
        logic [N_LOOPS_DEF*NBIT_LP_IV-1:0] step;
        logic [NBIT_N_ACTIVE-1:0]          n_active;
    } lp_cfg_t;

endpackage

// File: rtl/lp_level_cnt.sv
// One level of the loop nest: an iv register that steps when carried into
// and wraps to zero (raising carry out) once it would reach its bound.
module lp_level_cnt #(
    parameter int NBIT = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_clear,
    input  logic            i_hold,
    input  logic            i_enable,
    input  logic            i_carry,
    input  logic [NBIT-1:0] i_bound,
    input  logic [NBIT-1:0] i_step,
    output logic [NBIT-1:0] o_iv,
    output logic            o_carry
);

    logic [NBIT-1:0] r_iv;
    logic [NBIT:0]   w_nxt;
    logic            w_wrap;

    // The extra sum bit keeps a large step from aliasing back under the bound.
    assign w_nxt   = {1'b0, r_iv} + {1'b0, i_step};
    assign w_wrap  = (w_nxt >= {1'b0, i_bound});
    assign o_carry = i_enable ? (i_carry & w_wrap) : i_carry;
    assign o_iv    = r_iv;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_iv <= '0;
        end else if (i_clear) begin
            r_iv <= '0;
        end else if (!i_hold && i_enable && i_carry) begin
            r_iv <= w_wrap ? '0 : w_nxt[NBIT-1:0];
        end
    end

endmodule

// File: rtl/lp_iv_gen.sv
// Loop-nest induction-variable generator feeding the address generation engine.
// Optional iteration counter output enabled by defining MAGE_LP_ITER_CNT_EN.
module lp_iv_gen
    import mage_pkg::lp_iv_state_e;
    import mage_pkg::LP_IDLE;
    import mage_pkg::LP_RUN;
    import mage_pkg::LP_DONE;
    import mage_pkg::N_LOOPS_DEF;
#(
    parameter int N_LOOPS       = N_LOOPS_DEF,
    parameter int NBIT_LP_IV    = mage_pkg::NBIT_LP_IV,
    parameter int NBIT_ITER_CNT = mage_pkg::NBIT_ITER_CNT
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic                             stall_i,
    input  logic [N_LOOPS*NBIT_LP_IV-1:0]    bound_i,
    input  logic [N_LOOPS*NBIT_LP_IV-1:0]    step_i,
    input  logic [$clog2(N_LOOPS+1)-1:0]     n_active_i,
    output logic [N_LOOPS*NBIT_LP_IV-1:0]    iv_o,
    output logic                             valid_o,
    output logic                             acc_reset_o,
    output logic                             end_lp_o,
    output logic                             busy_o
`ifdef MAGE_LP_ITER_CNT_EN
    ,
    output logic [NBIT_ITER_CNT-1:0]         iter_cnt_o
`endif
);

    localparam int NA_W = $clog2(N_LOOPS + 1);

    lp_iv_state_e                     r_state;
    logic [N_LOOPS*NBIT_LP_IV-1:0]    r_bound;
    logic [N_LOOPS*NBIT_LP_IV-1:0]    r_step;
    logic [NA_W-1:0]                  r_n_active;
    logic                             r_valid;
    logic                             r_acc_reset;
    logic                             r_end_lp;
    logic                             r_busy;

    logic                             w_start;
    logic                             w_hold;
    logic                             w_zero_bound;
    logic [N_LOOPS-1:0]               w_enable;
    logic [N_LOOPS:0]                 w_carry;

    assign w_start    = (r_state == LP_IDLE) && start_i;
    assign w_hold     = stall_i || (r_state != LP_RUN);
    assign w_carry[0] = 1'b1;

    always_comb begin
        w_zero_bound = 1'b0;
        for (int i = 0; i < N_LOOPS; i++) begin
            if ((i < int'(n_active_i)) && (bound_i[i*NBIT_LP_IV +: NBIT_LP_IV] == '0)) begin
                w_zero_bound = 1'b1;
            end
        end
    end

    // Disabled levels pass the carry straight through, so the carry leaving
    // the top of the chain marks the final iteration for any n_active.
    for (genvar g = 0; g < N_LOOPS; g++) begin : g_level
        assign w_enable[g] = (g < int'(r_n_active));

        lp_level_cnt #(
            .NBIT (NBIT_LP_IV)
        ) u_level (
            .i_clk    (clk_i),
            .i_rst    (rst_i),
            .i_clear  (w_start),
            .i_hold   (w_hold),
            .i_enable (w_enable[g]),
            .i_carry  (w_carry[g]),
            .i_bound  (r_bound[g*NBIT_LP_IV +: NBIT_LP_IV]),
            .i_step   (r_step[g*NBIT_LP_IV +: NBIT_LP_IV]),
            .o_iv     (iv_o[g*NBIT_LP_IV +: NBIT_LP_IV]),
            .o_carry  (w_carry[g+1])
        );
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= LP_IDLE;
            r_bound     <= '0;
            r_step      <= '0;
            r_n_active  <= '0;
            r_valid     <= 1'b0;
            r_acc_reset <= 1'b0;
            r_end_lp    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                LP_IDLE: begin
                    r_end_lp <= 1'b0;
                    if (start_i) begin
                        r_bound    <= bound_i;
                        r_step     <= step_i;
                        r_n_active <= n_active_i;
                        if (w_zero_bound) begin
                            r_state  <= LP_DONE;
                            r_end_lp <= 1'b1;
                        end else begin
                            r_state     <= LP_RUN;
                            r_valid     <= 1'b1;
                            r_acc_reset <= 1'b1;
                            r_busy      <= 1'b1;
                        end
                    end
                end
                LP_RUN: begin
                    if (!stall_i) begin
                        if (w_carry[N_LOOPS]) begin
                            r_state     <= LP_DONE;
                            r_valid     <= 1'b0;
                            r_acc_reset <= 1'b0;
                            r_busy      <= 1'b0;
                            r_end_lp    <= 1'b1;
                        end else begin
                            // Innermost level wrapping means the next iv[0] is zero.
                            r_acc_reset <= w_carry[1];
                        end
                    end
                end
                LP_DONE: begin
                    r_end_lp <= 1'b0;
                    r_state  <= LP_IDLE;
                end
                default: begin
                    r_state <= LP_IDLE;
                end
            endcase
        end
    end

    assign valid_o     = r_valid;
    assign acc_reset_o = r_acc_reset;
    assign end_lp_o    = r_end_lp;
    assign busy_o      = r_busy;

`ifdef MAGE_LP_ITER_CNT_EN
    logic [NBIT_ITER_CNT-1:0] r_iter_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_iter_cnt <= '0;
        end else if (w_start) begin
            r_iter_cnt <= '0;
        end else if ((r_state == LP_RUN) && !stall_i && (r_iter_cnt != '1)) begin
            r_iter_cnt <= r_iter_cnt + NBIT_ITER_CNT'(1);
        end
    end

    assign iter_cnt_o = r_iter_cnt;
`endif

endmodule
